// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply/divide unit.
// It takes 16 iterations per op and ends with a one-cycle register-file write strobe.
module mul_div_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic [2:0]  destIn,
  output logic        busy,
  output logic        done,
  output logic [2:0]  writeReg,
  output logic [15:0] writeValue,
  output logic        RegWrite
);

  localparam int ITERS = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_DIV, OP_REM} op_t;

  typedef struct packed {
    op_t         op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
  } req_t;

  state_t      state;
  req_t        req;
  logic [4:0]  cnt;
  logic [31:0] acc;   // {product high, multiplier being shifted out}
  logic [16:0] rem;
  logic [15:0] quo;   // starts as dividend; quotient bits shift in at the bottom

  logic [16:0] mul_sum;
  logic [31:0] acc_nxt;
  logic [16:0] rem_sh;
  logic [17:0] trial;
  logic [16:0] rem_nxt;
  logic [15:0] quo_nxt;
  logic [15:0] result;

  // One shift-add step. The 17-bit sum keeps the carry that the right shift brings down.
  always_comb begin
    mul_sum = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, req.a} : 17'd0);
    acc_nxt = {mul_sum, acc[15:1]};
  end

  // One restoring-division step. A zero divisor never borrows, so the quotient
  // fills with ones and the dividend shifts whole into the remainder.
  always_comb begin
    rem_sh = {rem[15:0], quo[15]};
    trial  = {1'b0, rem_sh} - {2'b00, req.b};
    if (!trial[17]) begin
      rem_nxt = trial[16:0];
      quo_nxt = {quo[14:0], 1'b1};
    end else begin
      rem_nxt = rem_sh;
      quo_nxt = {quo[14:0], 1'b0};
    end
  end

  // The selection uses the next-state values, because the last iteration and the
  // write-back share one edge.
  always_comb begin
    result = '0;
    case (req.op)
      OP_MUL:  result = acc_nxt[15:0];
      OP_MULH: result = acc_nxt[31:16];
      OP_DIV:  result = quo_nxt;
      OP_REM:  result = rem_nxt[15:0];
      default: result = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      req        <= '0;
      cnt        <= '0;
      acc        <= '0;
      rem        <= '0;
      quo        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      RegWrite   <= 1'b0;
      writeReg   <= '0;
      writeValue <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req   <= '{op: op_t'(op), a: opA, b: opB, dest: destIn};
            acc   <= {16'h0000, opB};
            rem   <= '0;
            quo   <= opA;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITERS - 1)) begin
            writeValue <= result;
            writeReg   <= req.dest;
            done       <= 1'b1;
            RegWrite   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done     <= 1'b0;
          RegWrite <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
